grid_pipe_tester: RTL and testbench
===================================

# grid_pipe_tester

Self-checking test harness that instantiates a ROWS x COLS grid of registered passthrough lanes. A sequencer drives NUM_VECTORS deterministic stimulus words into every lane over multiple cycles. A latency-aware checker compares each lane output against its expected value and reports pass/fail, error counts and the first failure location. It generalises the single-cycle constant-value grid tester to parametrised width, lane latency, vector count and a fault-injection path for checker self-test.

## Interface
Parameters:
- ROWS, 2, grid rows (1..8)
- COLS, 2, grid columns (1..8)
- WIDTH, 32, lane data width in bits (1..64)
- LATENCY, 1, register stages per lane (0..8); 0 = combinational lane
- NUM_VECTORS, 16, stimulus words per run (1..65535)
- STEP, 1, per-vector stimulus increment
- LANE_W, derived, max(1, clog2(ROWS*COLS))

Ports (one clock `clock`; reset `reset` is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  run request; sampled only in IDLE or DONE
- inject_en  in  1  when 1, invert bit 0 of the selected lane's output before compare
- inject_lane  in  LANE_W  lane index L = r*COLS + c targeted by injection
- busy  out  1  high in DRIVE and DRAIN
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_count == 0
- err_count  out  16  saturating count of mismatching lane-checks
- first_err_lane  out  LANE_W  lane of first mismatch
- first_err_vec  out  16  vector index of first mismatch

## Operation
- Lane L: LATENCY-deep WIDTH-bit register chain; all stages reset to 0.
- Stimulus for lane L, vector k: (L + k*STEP) mod 2^WIDTH. Lanes are driven 0 outside DRIVE.
- FSM states:
  - IDLE: start=1 -> DRIVE. Clear err_count, first_err_*, and the error-seen flag.
  - DRIVE: vector counter k = 0..NUM_VECTORS-1, one vector per cycle. After the last vector: -> DRAIN if LATENCY>0, else -> DONE.
  - DRAIN: LATENCY cycles, then -> DONE.
  - DONE: status held. start=1 -> DRIVE and clears counters, as in IDLE.
- Checker uses a LATENCY-delayed copy of (valid, k). When valid, every lane is compared against the expected value for the delayed k.
  - err_count += number of mismatching lanes that cycle, saturating at 16'hFFFF.
  - On the first mismatching cycle of a run, capture the lowest-index mismatching lane and its k. Later mismatches leave these unchanged.
- start in DRIVE/DRAIN is ignored. inject_en is honoured on every valid check cycle.

## Timing
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_lane=0, first_err_vec=0; state IDLE.
- start sampled at edge t -> busy=1 from t+1 for NUM_VECTORS+LATENCY cycles. done=1 and pass valid from cycle t+1+NUM_VECTORS+LATENCY.
- Lane output for vector k appears LATENCY cycles after it is driven. Compare is same-cycle combinational and registered into the counters at the next edge.
- Reset asserted mid-run: next edge returns to IDLE, all outputs return to reset values, and lane pipes are flushed to 0.
- err_count at 16'hFFFF stays there; pass=0.

## Configuration
- TAB_TESTER_FATAL_EN defined: non-synthesis simulation tasks are compiled in.
  - On any mismatch cycle while not in reset: $fwrite failure message (lane, vector, got, expected) to stderr, then $fatal.
  - On entering DONE with pass=1: $finish.
- Undefined: no simulation tasks. Behaviour is reported only through the status ports.

## Test plan
- Defaults, start pulse at cycle 0, inject_en=0 -> busy cycles 1..17; done=1 from cycle 18; pass=1; err_count=0. Lane 3 output equals 8 one cycle after vector 5 is driven.
- Defaults, inject_en=1, inject_lane=2 -> err_count=16, first_err_lane=2, first_err_vec=0, pass=0.
- LATENCY=0, NUM_VECTORS=4, inject_en=1, inject_lane=0 asserted only during vectors 2..3 -> done at cycle 5, err_count=2, first_err_vec=2.
- WIDTH=4, STEP=3, NUM_VECTORS=8 -> lane 3 vector 7 expected 8 (24 mod 16); pass=1.
- Reset asserted at cycle 6 of a default run -> next cycle busy=0, err_count=0, state IDLE; fresh start completes with pass=1.
- Run with injection to DONE (err_count=16), then restart without injection -> err_count cleared at restart; final pass=1, err_count=0.

Source files
------------

// File: rtl/grid_pipe_tester.sv
// grid_pipe_tester: ROWS x COLS grid of LATENCY-deep registered passthrough
// lanes driven by a deterministic stimulus sequencer, with a latency-aware
// checker that reports pass/fail, a saturating error count and the first
// failing lane/vector. A fault-injection path flips bit 0 of one lane before
// the compare so the checker itself can be exercised.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start               run request, honoured only in IDLE or DONE
//   inject_en/lane      invert bit 0 of lane inject_lane before compare
//   busy                high while driving or draining
//   done, pass          run complete / complete with zero mismatches
//   err_count           saturating count of mismatching lane-checks
//   first_err_lane/vec  location of the first mismatch of the run
//
// Optional macro: TAB_TESTER_FATAL_EN compiles in simulation-only reporting
// ($fatal on any mismatch, $finish on a passing run).
module grid_pipe_tester #(
  parameter int unsigned ROWS        = 2,
  parameter int unsigned COLS        = 2,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned STEP        = 1,
  parameter int unsigned LANE_W      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              inject_en,
  input  logic [LANE_W-1:0] inject_lane,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [LANE_W-1:0] first_err_lane,
  output logic [15:0]       first_err_vec
);

  localparam int unsigned NUM_LANES = ROWS * COLS;
  localparam int unsigned CNT_W     = $clog2(NUM_LANES + 1);
  localparam int unsigned DRAIN_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} stateT;

  stateT                          state, nextState;
  logic                           launch;
  logic [15:0]                    vecCnt;
  logic [DRAIN_W-1:0]             drainCnt;
  logic [NUM_LANES-1:0][WIDTH-1:0] laneIn, laneOut, laneChk;
  logic                           checkValid;
  logic [15:0]                    checkVec;
  logic [CNT_W-1:0]               missCnt;
  logic                           anyMiss;
  logic [LANE_W-1:0]              missLane;
  logic [16:0]                    errSum;
  logic [15:0]                    nextErrCount;
  logic                           errSeen;

  // Stimulus word for a lane/vector pair: (lane + k*STEP) mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] stimulus(input int unsigned lane, input logic [15:0] k);
    logic [63:0] acc;
    acc = 64'(lane) + 64'(k) * 64'(STEP);
    return WIDTH'(acc);
  endfunction

  // Next-state decode; launch marks an accepted start.
  always_comb begin
    nextState = state;
    launch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nextState = DRIVE;
          launch    = 1'b1;
        end
      end
      DRIVE:   if (vecCnt == LAST_VEC) nextState = (LATENCY > 0) ? DRAIN : DONE;
      DRAIN:   if (drainCnt == LAST_DRAIN) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  // State register with registered status decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nextState;
      busy  <= (nextState == DRIVE) || (nextState == DRAIN);
      done  <= (nextState == DONE);
    end
  end

  // Vector and drain counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      vecCnt   <= '0;
      drainCnt <= '0;
    end else begin
      vecCnt   <= (state == DRIVE && vecCnt != LAST_VEC) ? vecCnt + 16'd1 : 16'd0;
      drainCnt <= (state == DRAIN) ? drainCnt + DRAIN_W'(1) : '0;
    end
  end

  // Lanes see stimulus only while driving.
  always_comb begin
    laneIn = '0;
    if (state == DRIVE) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) laneIn[l] = stimulus(l, vecCnt);
    end
  end

  // Lane register chains plus matching (valid, k) tag pipe for the checker.
  generate
    if (LATENCY == 0) begin : gNoPipe
      assign laneOut    = laneIn;
      assign checkValid = (state == DRIVE);
      assign checkVec   = vecCnt;
    end else begin : gPipe
      logic [LATENCY-1:0][NUM_LANES-1:0][WIDTH-1:0] stage;
      logic [LATENCY-1:0]                           validPipe;
      logic [LATENCY-1:0][15:0]                     vecPipe;

      always_ff @(posedge clock) begin
        if (reset) begin
          stage     <= '0;
          validPipe <= '0;
          vecPipe   <= '0;
        end else begin
          stage[0]     <= laneIn;
          validPipe[0] <= (state == DRIVE);
          vecPipe[0]   <= vecCnt;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            stage[i]     <= stage[i-1];
            validPipe[i] <= validPipe[i-1];
            vecPipe[i]   <= vecPipe[i-1];
          end
        end
      end

      assign laneOut    = stage[LATENCY-1];
      assign checkValid = validPipe[LATENCY-1];
      assign checkVec   = vecPipe[LATENCY-1];
    end
  endgenerate

  // Compare every lane against its expected word; track lowest failing lane.
  always_comb begin
    laneChk  = laneOut;
    missCnt  = '0;
    anyMiss  = 1'b0;
    missLane = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (inject_en && inject_lane == LANE_W'(l)) laneChk[l][0] = ~laneOut[l][0];
    end
    if (checkValid) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (laneChk[l] != stimulus(l, checkVec)) begin
          if (!anyMiss) missLane = LANE_W'(l);
          anyMiss = 1'b1;
          missCnt = missCnt + CNT_W'(1);
        end
      end
    end
    errSum       = {1'b0, err_count} + 17'(missCnt);
    nextErrCount = errSum[16] ? 16'hFFFF : errSum[15:0];
  end

  // Error status; cleared on every accepted start.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_count      <= '0;
      first_err_lane <= '0;
      first_err_vec  <= '0;
      errSeen        <= 1'b0;
      pass           <= 1'b0;
    end else begin
      if (launch) begin
        err_count      <= '0;
        first_err_lane <= '0;
        first_err_vec  <= '0;
        errSeen        <= 1'b0;
      end else if (checkValid) begin
        err_count <= nextErrCount;
        if (anyMiss && !errSeen) begin
          errSeen        <= 1'b1;
          first_err_lane <= missLane;
          first_err_vec  <= checkVec;
        end
      end
      // The last check lands on the same edge that enters DONE.
      pass <= (nextState == DONE) && ((checkValid ? nextErrCount : err_count) == 16'd0);
    end
  end

`ifdef TAB_TESTER_FATAL_EN
  // Simulation-only reporting: stop hard on a mismatch, finish on a clean run.
  always @(posedge clock) begin
    if (!reset && checkValid && anyMiss) begin
      $fatal(1, "grid_pipe_tester: lane %0d vector %0d got %h expected %h",
             missLane, checkVec, laneChk[missLane], stimulus(32'(missLane), checkVec));
    end
    if (!reset && state != DONE && nextState == DONE &&
        ((checkValid ? nextErrCount : err_count) == 16'd0)) begin
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_grid_pipe_tester.sv
// Bench for grid_pipe_tester: three parameterisations share one clock.
//   dut 0: defaults (2x2, 32-bit, LATENCY 1, 16 vectors, STEP 1)
//   dut 1: LATENCY 0, 4 vectors
//   dut 2: 3x2, 4-bit, LATENCY 2, 8 vectors, STEP 3 (lanes 6,7 do not exist)
module tb_grid_pipe_tester;

  logic clock;
  logic reset;

  logic startA, injEnA, busyA, doneA, passA;
  logic [1:0] injLaneA, flA;
  logic [15:0] errA, fvA;
  logic startB, injEnB, busyB, doneB, passB;
  logic [1:0] injLaneB, flB;
  logic [15:0] errB, fvB;
  logic startC, injEnC, busyC, doneC, passC;
  logic [2:0] injLaneC, flC;
  logic [15:0] errC, fvC;

  grid_pipe_tester dutA (
    .clock(clock), .reset(reset), .start(startA), .inject_en(injEnA), .inject_lane(injLaneA),
    .busy(busyA), .done(doneA), .pass(passA), .err_count(errA),
    .first_err_lane(flA), .first_err_vec(fvA));

  grid_pipe_tester #(.LATENCY(0), .NUM_VECTORS(4)) dutB (
    .clock(clock), .reset(reset), .start(startB), .inject_en(injEnB), .inject_lane(injLaneB),
    .busy(busyB), .done(doneB), .pass(passB), .err_count(errB),
    .first_err_lane(flB), .first_err_vec(fvB));

  grid_pipe_tester #(.ROWS(3), .COLS(2), .WIDTH(4), .LATENCY(2), .NUM_VECTORS(8), .STEP(3)) dutC (
    .clock(clock), .reset(reset), .start(startC), .inject_en(injEnC), .inject_lane(injLaneC),
    .busy(busyC), .done(doneC), .pass(passC), .err_count(errC),
    .first_err_lane(flC), .first_err_vec(fvC));

  // Per-dut configuration as seen by the reference model.
  int NV_T[3]    = '{16, 4, 8};
  int LAT_T[3]   = '{1, 0, 2};
  int NL_T[3]    = '{4, 4, 6};
  int STEP_T[3]  = '{1, 1, 3};
  int WID_T[3]   = '{32, 32, 4};
  int LMAX_T[3]  = '{3, 3, 7};

  int checks = 0;
  int errors = 0;

  // Per-cycle (relative to the start edge) stimulus for one run.
  bit runEn[32];
  int runLane[32];
  bit runStart[32];

  typedef struct {
    bit en;
    int lane;
    int expErr;
    int expLane;
    int expVec;
    bit expPass;
  } vecT;

  vecT tbl[5];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic setIn(input int d, input bit st, input bit en, input int lane);
    case (d)
      0: begin startA = st; injEnA = en; injLaneA = 2'(lane); end
      1: begin startB = st; injEnB = en; injLaneB = 2'(lane); end
      default: begin startC = st; injEnC = en; injLaneC = 3'(lane); end
    endcase
  endtask

  function automatic longint unsigned getBusy(input int d);
    return (d == 0) ? 64'(busyA) : (d == 1) ? 64'(busyB) : 64'(busyC);
  endfunction
  function automatic longint unsigned getDone(input int d);
    return (d == 0) ? 64'(doneA) : (d == 1) ? 64'(doneB) : 64'(doneC);
  endfunction
  function automatic longint unsigned getPass(input int d);
    return (d == 0) ? 64'(passA) : (d == 1) ? 64'(passB) : 64'(passC);
  endfunction
  function automatic longint unsigned getErr(input int d);
    return (d == 0) ? 64'(errA) : (d == 1) ? 64'(errB) : 64'(errC);
  endfunction
  function automatic longint unsigned getFl(input int d);
    return (d == 0) ? 64'(flA) : (d == 1) ? 64'(flB) : 64'(flC);
  endfunction
  function automatic longint unsigned getFv(input int d);
    return (d == 0) ? 64'(fvA) : (d == 1) ? 64'(fvB) : 64'(fvC);
  endfunction
  function automatic longint unsigned getLane(input int d, input int l);
    case (d)
      0: return 64'(dutA.laneOut[l]);
      1: return 64'(dutB.laneOut[l]);
      default: return 64'(dutC.laneOut[l]);
    endcase
  endfunction

  // Full run on dut d using runEn/runLane/runStart; called at a negedge.
  task automatic doRun(input int d);
    int nv, lat, nl, kk, last;
    int expErr, expLane, expVec;
    bit seen;
    longint unsigned mask, expW;
    nv  = NV_T[d];
    lat = LAT_T[d];
    nl  = NL_T[d];
    last = nv + lat + 1;
    mask = (WID_T[d] >= 64) ? '1 : ((64'd1 << WID_T[d]) - 64'd1);
    // Vector k is compared in cycle 1+k+LATENCY; injection there flips one lane.
    expErr = 0; expLane = 0; expVec = 0; seen = 0;
    for (int k = 0; k < nv; k++) begin
      if (runEn[1 + k + lat] && runLane[1 + k + lat] < nl) begin
        expErr++;
        if (!seen) begin
          seen = 1;
          expLane = runLane[1 + k + lat];
          expVec = k;
        end
      end
    end
    setIn(d, 1'b1, runEn[0], runLane[0]);
    @(negedge clock);
    for (int c = 1; c <= last; c++) begin
      check($sformatf("d%0d c%0d busy", d, c), getBusy(d), (c <= nv + lat) ? 64'd1 : 64'd0);
      check($sformatf("d%0d c%0d done", d, c), getDone(d), (c == last) ? 64'd1 : 64'd0);
      kk = c - 1 - lat;
      for (int l = 0; l < nl; l++) begin
        expW = (kk >= 0 && kk < nv) ? ((64'(l) + 64'(kk) * 64'(STEP_T[d])) & mask) : 64'd0;
        check($sformatf("d%0d c%0d lane%0d", d, c, l), getLane(d, l), expW);
      end
      setIn(d, (c < last) ? runStart[c] : 1'b0, runEn[c], runLane[c]);
      if (c < last) @(negedge clock);
    end
    check($sformatf("d%0d err_count", d), getErr(d), 64'(expErr));
    check($sformatf("d%0d pass", d), getPass(d), (expErr == 0) ? 64'd1 : 64'd0);
    check($sformatf("d%0d first_lane", d), getFl(d), 64'(expLane));
    check($sformatf("d%0d first_vec", d), getFv(d), 64'(expVec));
    setIn(d, 1'b0, 1'b0, 0);
    @(negedge clock);
  endtask

  task automatic clearRun();
    for (int i = 0; i < 32; i++) begin
      runEn[i] = 1'b0;
      runLane[i] = 0;
      runStart[i] = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{en: 1'b0, lane: 0, expErr: 0,  expLane: 0, expVec: 0, expPass: 1'b1};
    tbl[1] = '{en: 1'b1, lane: 2, expErr: 16, expLane: 2, expVec: 0, expPass: 1'b0};
    tbl[2] = '{en: 1'b0, lane: 1, expErr: 0,  expLane: 0, expVec: 0, expPass: 1'b1};
    tbl[3] = '{en: 1'b1, lane: 3, expErr: 16, expLane: 3, expVec: 0, expPass: 1'b0};
    tbl[4] = '{en: 1'b1, lane: 0, expErr: 16, expLane: 0, expVec: 0, expPass: 1'b0};

    reset = 1'b1;
    for (int d = 0; d < 3; d++) setIn(d, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset busy", d), getBusy(d), 64'd0);
      check($sformatf("d%0d reset done", d), getDone(d), 64'd0);
      check($sformatf("d%0d reset pass", d), getPass(d), 64'd0);
      check($sformatf("d%0d reset err", d), getErr(d), 64'd0);
      check($sformatf("d%0d reset fl", d), getFl(d), 64'd0);
      check($sformatf("d%0d reset fv", d), getFv(d), 64'd0);
    end
    reset = 1'b0;
    @(negedge clock);

    // Constant-injection runs on the default grid; includes restart clearing.
    for (int t = 0; t < 5; t++) begin
      clearRun();
      for (int i = 0; i < 32; i++) begin
        runEn[i] = tbl[t].en;
        runLane[i] = tbl[t].lane;
      end
      doRun(0);
      check($sformatf("tbl%0d err", t), getErr(0), 64'(tbl[t].expErr));
      check($sformatf("tbl%0d lane", t), getFl(0), 64'(tbl[t].expLane));
      check($sformatf("tbl%0d vec", t), getFv(0), 64'(tbl[t].expVec));
      check($sformatf("tbl%0d pass", t), getPass(0), 64'(tbl[t].expPass));
    end

    // Combinational lanes, injection only while vectors 2..3 are checked.
    clearRun();
    runEn[3] = 1'b1;
    runEn[4] = 1'b1;
    doRun(1);
    check("lat0 err", getErr(1), 64'd2);
    check("lat0 vec", getFv(1), 64'd2);
    check("lat0 pass", getPass(1), 64'd0);

    // Narrow wrapping lanes, clean run.
    clearRun();
    doRun(2);
    check("narrow pass", getPass(2), 64'd1);

    // Reset in the middle of an injected default run.
    clearRun();
    setIn(0, 1'b1, 1'b1, 1);
    @(negedge clock);
    setIn(0, 1'b0, 1'b1, 1);
    repeat (5) @(negedge clock);
    check("midrst err before", getErr(0), 64'd4);
    check("midrst busy before", getBusy(0), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst busy", getBusy(0), 64'd0);
    check("midrst done", getDone(0), 64'd0);
    check("midrst err", getErr(0), 64'd0);
    check("midrst fl", getFl(0), 64'd0);
    for (int l = 0; l < 4; l++) check($sformatf("midrst lane%0d", l), getLane(0, l), 64'd0);
    reset = 1'b0;
    setIn(0, 1'b0, 1'b0, 0);
    @(negedge clock);
    check("midrst idle done", getDone(0), 64'd0);
    doRun(0);
    check("midrst rerun pass", getPass(0), 64'd1);

    // Randomised per-cycle injection and ignored mid-run starts.
    for (int r = 0; r < 12; r++) begin
      int d;
      d = r % 3;
      clearRun();
      for (int i = 0; i < 32; i++) begin
        runEn[i] = ($urandom_range(3) == 0);
        runLane[i] = int'($urandom_range(LMAX_T[d]));
        runStart[i] = ($urandom_range(4) == 0);
      end
      doRun(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
